// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants, address-width helper, read-port array types
// and the reset-value function for the regfile_sb register file.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int NRD_MAX   = 4;

    // Address width for a file of nregs registers (nregs is a power of two, >= 2).
    function automatic int calc_aw(input int nregs);
        return (nregs < 2) ? 1 : $clog2(nregs);
    endfunction

    localparam int AW_DEF = calc_aw(NREGS_DEF);

    // Read-port address/data arrays at the default geometry.
    typedef logic [NRD_MAX-1:0][AW_DEF-1:0]   rd_addr_arr_t;
    typedef logic [NRD_MAX-1:0][XLEN_DEF-1:0] rd_data_arr_t;

    // Reset contents of register idx before truncation to the data width.
    function automatic logic [63:0] reset_value(input int idx, input int stride);
        return 64'(idx) * 64'(stride);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits for pending long-latency writes,
// issue/clear priority, sticky protocol-error flag and per-read-port busy lookup.
// Optional macro REGFILE_BYPASS_EN: a wr1 clear this cycle hides busy on reads.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2,
    localparam int AW   = calc_aw(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    input  logic              wr1_en,
    input  logic [AW-1:0]     wr1_addr,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    rd_busy,
    output logic              sb_err
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             sb_err_q;
    logic             sb_err_d;

    // Next busy vector: wr1 clears, a same-cycle issue to the same register wins.
    always_comb begin
        busy_d = busy_q;
        if (wr1_en) begin
            busy_d[wr1_addr] = 1'b0;
        end
        if (iss_en && (iss_addr != '0)) begin
            busy_d[iss_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Sticky error: issue to a busy register not being cleared, or wr1 to a non-busy one.
    always_comb begin
        sb_err_d = sb_err_q;
        if (iss_en && busy_q[iss_addr] && !(wr1_en && (wr1_addr == iss_addr))) begin
            sb_err_d = 1'b1;
        end
        if (wr1_en && (wr1_addr != '0) && !busy_q[wr1_addr]) begin
            sb_err_d = 1'b1;
        end
    end

    // Scoreboard state; reset drops every pending write immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= '0;
            sb_err_q <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            sb_err_q <= sb_err_d;
        end
    end

    // Per-port busy lookup, optionally hiding a register being cleared this cycle.
    always_comb begin
        rd_busy = '0;
        for (int k = 0; k < NRD; k++) begin
            rd_busy[k] = busy_q[rd_addr[k*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
            if (wr1_en && (wr1_addr == rd_addr[k*AW +: AW]) &&
                !(iss_en && (iss_addr == rd_addr[k*AW +: AW]))) begin
                rd_busy[k] = 1'b0;
            end
`endif
        end
    end

    assign sb_err = sb_err_q;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: multi-read, dual-write register file with a pending-write
// scoreboard. Port 0 carries ALU results, port 1 carries long-latency results
// and clears busy. Register 0 is hard-wired to zero.
// Optional macro REGFILE_BYPASS_EN: same-cycle write data forwarded to reads.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN         = XLEN_DEF,
    parameter int NREGS        = NREGS_DEF,
    parameter int NRD          = 2,
    parameter int RESET_STRIDE = 10,
    localparam int AW          = calc_aw(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    output logic                hazard,
    input  logic                wr0_en,
    input  logic [AW-1:0]       wr0_addr,
    input  logic [XLEN-1:0]     wr0_data,
    input  logic                wr1_en,
    input  logic [AW-1:0]       wr1_addr,
    input  logic [XLEN-1:0]     wr1_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    output logic                sb_err
);

    logic [XLEN-1:0] storage_q [NREGS];
    logic [XLEN-1:0] storage_d [NREGS];

    // Reset contents of register idx, truncated to the data width; r0 is zero.
    function automatic logic [XLEN-1:0] reset_word(input int idx);
        if (idx == 0) begin
            return '0;
        end
        return XLEN'(reset_value(idx, RESET_STRIDE));
    endfunction

    // Next storage: wr1 applied first so a colliding wr0 overwrites it; r0 never written.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            storage_d[r] = storage_q[r];
        end
        if (wr1_en && (wr1_addr != '0)) begin
            storage_d[wr1_addr] = wr1_data;
        end
        if (wr0_en && (wr0_addr != '0)) begin
            storage_d[wr0_addr] = wr0_data;
        end
    end

    // Storage registers; reset restores the stride pattern.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                storage_q[r] <= reset_word(r);
            end
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                storage_q[r] <= storage_d[r];
            end
        end
    end

    // Read ports: storage lookup, optionally forwarding same-cycle writes (wr0 first).
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NRD; k++) begin
            if (rd_addr[k*AW +: AW] != '0) begin
                rd_data[k*XLEN +: XLEN] = storage_q[rd_addr[k*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
                if (rst_n && wr0_en && (wr0_addr == rd_addr[k*AW +: AW])) begin
                    rd_data[k*XLEN +: XLEN] = wr0_data;
                end else if (rst_n && wr1_en && (wr1_addr == rd_addr[k*AW +: AW])) begin
                    rd_data[k*XLEN +: XLEN] = wr1_data;
                end
`endif
            end
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .wr1_en   (wr1_en),
        .wr1_addr (wr1_addr),
        .rd_addr  (rd_addr),
        .rd_busy  (rd_busy),
        .sb_err   (sb_err)
    );

    assign hazard = |rd_busy;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: self-checking bench for regfile_sb. Expected observations are
// queued when stimulus is applied and popped when the DUT output is sampled.
// Expectations follow the build's REGFILE_BYPASS_EN setting.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        hazard;
    logic        wr0_en;
    logic [4:0]  wr0_addr;
    logic [31:0] wr0_data;
    logic        wr1_en;
    logic [4:0]  wr1_addr;
    logic [31:0] wr1_data;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic        sb_err;

    typedef struct {
        string       name;
        logic [67:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    wire [67:0] obs = {rd_data, rd_busy, hazard, sb_err};

    assign rd_addr = {a1, a0};

    regfile_sb #(
        .XLEN         (32),
        .NREGS        (32),
        .NRD          (2),
        .RESET_STRIDE (10)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .hazard   (hazard),
        .wr0_en   (wr0_en),
        .wr0_addr (wr0_addr),
        .wr0_data (wr0_data),
        .wr1_en   (wr1_en),
        .wr1_addr (wr1_addr),
        .wr1_data (wr1_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .sb_err   (sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Queue one expected observation: port0/port1 data, port busy bits, sticky error.
    function automatic void push_exp(input string n, input logic [31:0] d0, input logic [31:0] d1,
                                     input logic b0, input logic b1, input logic err);
        exp_t t;
        t.name = n;
        t.v    = {d1, d0, b1, b0, b0 | b1, err};
        exp_q.push_back(t);
    endfunction

    task automatic idle();
        wr0_en = 1'b0;
        wr1_en = 1'b0;
        iss_en = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        idle();
        wr0_addr = '0; wr0_data = '0; wr1_addr = '0; wr1_data = '0; iss_addr = '0;
        a0 = 5'd5; a1 = 5'd31;
        repeat (2) @(posedge clk);
        @(negedge clk);
        push_exp("reset_hold", 32'd50, 32'd310, 1'b0, 1'b0, 1'b0);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
        rst_n = 1'b1;
        @(negedge clk);
        push_exp("reset_r5_r31", 32'd50, 32'd310, 1'b0, 1'b0, 1'b0);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
        a0 = 5'd0;
        push_exp("reset_r0", 32'd0, 32'd310, 1'b0, 1'b0, 1'b0);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    endtask

    task automatic test_collision();
        exp_t e;
        @(negedge clk);
        a0 = 5'd3; a1 = 5'd0;
        iss_en = 1'b1; iss_addr = 5'd3;
        push_exp("coll_iss_comb", 32'd30, 32'd0, 1'b0, 1'b0, 1'b0);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
        @(negedge clk);
        idle();
        push_exp("coll_busy", 32'd30, 32'd0, 1'b1, 1'b0, 1'b0);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
        wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'hAAAA;
        wr1_en = 1'b1; wr1_addr = 5'd3; wr1_data = 32'h5555;
        push_exp("coll_same_cycle", BYP ? 32'hAAAA : 32'd30, 32'd0, !BYP, 1'b0, 1'b0);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
        @(negedge clk);
        idle();
        push_exp("coll_r3_wr0_wins", 32'hAAAA, 32'd0, 1'b0, 1'b0, 1'b0);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
        a0 = 5'd0; a1 = 5'd3;
        wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'hFFFF;
        push_exp("r0_write_comb", 32'd0, 32'hAAAA, 1'b0, 1'b0, 1'b0);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
        @(negedge clk);
        idle();
        push_exp("r0_still_zero", 32'd0, 32'hAAAA, 1'b0, 1'b0, 1'b0);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    endtask

    task automatic test_roundtrip();
        exp_t e;
        @(negedge clk);
        idle();
        a0 = 5'd7; a1 = 5'd9;
        iss_en = 1'b1; iss_addr = 5'd7;
        push_exp("rt_iss_comb", 32'd70, 32'd90, 1'b0, 1'b0, 1'b0);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
        @(negedge clk);
        idle();
        push_exp("rt_busy", 32'd70, 32'd90, 1'b1, 1'b0, 1'b0);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
        repeat (2) @(negedge clk);
        push_exp("rt_busy_held", 32'd70, 32'd90, 1'b1, 1'b0, 1'b0);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
        wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h1234;
        push_exp("rt_wb_comb", BYP ? 32'h1234 : 32'd70, 32'd90, !BYP, 1'b0, 1'b0);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
        @(negedge clk);
        idle();
        push_exp("rt_done", 32'h1234, 32'd90, 1'b0, 1'b0, 1'b0);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    endtask

    task automatic test_issue_clear();
        exp_t e;
        @(negedge clk);
        idle();
        a0 = 5'd9; a1 = 5'd7;
        iss_en = 1'b1; iss_addr = 5'd9;
        @(negedge clk);
        idle();
        push_exp("ic_busy", 32'd90, 32'h1234, 1'b1, 1'b0, 1'b0);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
        iss_en = 1'b1; iss_addr = 5'd9;
        wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 32'h99;
        push_exp("ic_same_cycle", BYP ? 32'h99 : 32'd90, 32'h1234, 1'b1, 1'b0, 1'b0);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
        @(negedge clk);
        idle();
        push_exp("ic_stays_busy", 32'h99, 32'h1234, 1'b1, 1'b0, 1'b0);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
        wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'h77;
        @(negedge clk);
        idle();
        push_exp("waw_busy_kept", 32'h77, 32'h1234, 1'b1, 1'b0, 1'b0);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
        wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 32'h88;
        @(negedge clk);
        idle();
        push_exp("ic_cleared", 32'h88, 32'h1234, 1'b0, 1'b0, 1'b0);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    endtask

    task automatic test_errors();
        exp_t e;
        @(negedge clk);
        idle();
        a0 = 5'd4; a1 = 5'd2;
        iss_en = 1'b1; iss_addr = 5'd4;
        @(negedge clk);
        idle();
        push_exp("err_first_iss", 32'd40, 32'd20, 1'b1, 1'b0, 1'b0);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
        iss_en = 1'b1; iss_addr = 5'd4;
        @(negedge clk);
        idle();
        push_exp("err_double_iss", 32'd40, 32'd20, 1'b1, 1'b0, 1'b1);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
        repeat (3) @(negedge clk);
        push_exp("err_sticky", 32'd40, 32'd20, 1'b1, 1'b0, 1'b1);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
        rst_n = 1'b0;
        push_exp("err_reset_clears", 32'd40, 32'd20, 1'b0, 1'b0, 1'b0);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
        @(negedge clk);
        rst_n = 1'b1;
        wr1_en = 1'b1; wr1_addr = 5'd2; wr1_data = 32'h22;
        @(negedge clk);
        idle();
        push_exp("err_wr1_not_busy", 32'd40, 32'h22, 1'b0, 1'b0, 1'b1);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset_midflight();
        exp_t e;
        @(negedge clk);
        idle();
        a0 = 5'd10; a1 = 5'd11;
        iss_en = 1'b1; iss_addr = 5'd10;
        @(negedge clk);
        iss_en = 1'b1; iss_addr = 5'd11;
        @(negedge clk);
        idle();
        push_exp("mf_both_busy", 32'd100, 32'd110, 1'b1, 1'b1, 1'b0);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
        wr0_en = 1'b1; wr0_addr = 5'd10; wr0_data = 32'hBEEF;
        #1;
        rst_n = 1'b0;
        push_exp("mf_reset_immediate", 32'd100, 32'd110, 1'b0, 1'b0, 1'b0);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
        @(negedge clk);
        idle();
        push_exp("mf_write_dropped", 32'd100, 32'd110, 1'b0, 1'b0, 1'b0);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
        rst_n = 1'b1;
        @(negedge clk);
        push_exp("mf_released", 32'd100, 32'd110, 1'b0, 1'b0, 1'b0);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    endtask

    initial begin
        test_reset();
        test_collision();
        test_roundtrip();
        test_issue_clear();
        test_errors();
        test_reset_midflight();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drained: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
